// File: rtl/carwash_seg_monitor.sv
// carwash_seg_monitor: receive-side checker for the car-wash 7-segment display.
// The wash controller drives two digits. seg2_i is the left digit and seg_i is the right digit.
// Each digit pair is deglitched, decoded into a step token and checked against the
// Basic, Express and Premium step sequences.
// Optional feature: define CARWASH_MON_ERRCNT_EN to add err_count_o, a saturating
// count of seq_err and abort events.
module carwash_seg_monitor #(
  parameter int STABLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg2_i,
  input  logic [6:0]       seg_i,
  output logic             step_valid_o,
  output logic [4:0]       step_code_o,
  output logic [1:0]       program_o,
  output logic             wash_done_o,
  output logic             abort_o,
  output logic             seq_err_o,
  output logic [CNT_W-1:0] wash_count_o
`ifdef CARWASH_MON_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_count_o
`endif
);

  // Segment characters, bit6=a .. bit0=g
  localparam logic [6:0] CH_DASH = 7'b0000001, CH_B = 7'b0011111, CH_P = 7'b1100111,
                         CH_E    = 7'b1001111, CH_S = 7'b1011011, CH_F = 7'b1000111,
                         CH_C    = 7'b1001110, CH_R = 7'b1000110, CH_I = 7'b0000110,
                         CH_9    = 7'b1110011, CH_U = 7'b0111110, CH_D = 7'b0111101,
                         CH_H    = 7'b0110111, CH_BL = 7'b0000000;

  localparam logic [4:0] T_IDLE = 5'd0,  T_BP = 5'd1,  T_EP = 5'd2,  T_PP = 5'd3,
                         T_PS   = 5'd4,  T_SF = 5'd5,  T_C  = 5'd6,  T_RI = 5'd7,
                         T_NINE = 5'd8,  T_UU = 5'd9,  T_D  = 5'd10, T_RS = 5'd11,
                         T_SH   = 5'd12, T_UNK = 5'd31;

  localparam int         RUN_W     = $clog2(STABLE_CYC + 1);
  localparam logic [13:0] IDLE_PAIR = {CH_DASH, CH_DASH};

  typedef enum logic [1:0] {MON_IDLE, MON_RUN, MON_DONE, MON_ERR} mon_state_e;

  // Map a digit pair to its step token.
  function automatic logic [4:0] decode(input logic [13:0] p);
    case (p)
      {CH_DASH, CH_DASH}: decode = T_IDLE;
      {CH_B, CH_P}:       decode = T_BP;
      {CH_E, CH_P}:       decode = T_EP;
      {CH_P, CH_P}:       decode = T_PP;
      {CH_P, CH_S}:       decode = T_PS;
      {CH_S, CH_F}:       decode = T_SF;
      {CH_C, CH_BL}:      decode = T_C;
      {CH_R, CH_I}:       decode = T_RI;
      {CH_9, CH_BL}:      decode = T_NINE;
      {CH_U, CH_U}:       decode = T_UU;
      {CH_D, CH_BL}:      decode = T_D;
      {CH_R, CH_S}:       decode = T_RS;
      {CH_S, CH_H}:       decode = T_SH;
      default:            decode = T_UNK;
    endcase
  endfunction

  // Return the token expected at position idx of a program's sequence.
  // Position 0 is the start token. Every sequence ends with NINE.
  function automatic logic [4:0] expected(input logic [1:0] prog, input logic [3:0] idx);
    expected = T_UNK;
    case (prog)
      2'd1: case (idx)
              4'd1: expected = T_SF;  4'd2: expected = T_C;
              4'd3: expected = T_RI;  4'd4: expected = T_NINE;
              default: expected = T_UNK;
            endcase
      2'd2: case (idx)
              4'd1: expected = T_PS;  4'd2: expected = T_C;
              4'd3: expected = T_SF;  4'd4: expected = T_C;
              4'd5: expected = T_RI;  4'd6: expected = T_NINE;
              default: expected = T_UNK;
            endcase
      2'd3: case (idx)
              4'd1:  expected = T_PS;  4'd2:  expected = T_C;
              4'd3:  expected = T_SF;  4'd4:  expected = T_C;
              4'd5:  expected = T_RI;  4'd6:  expected = T_UU;
              4'd7:  expected = T_C;   4'd8:  expected = T_RI;
              4'd9:  expected = T_D;   4'd10: expected = T_RS;
              4'd11: expected = T_SH;  4'd12: expected = T_NINE;
              default: expected = T_UNK;
            endcase
      default: expected = T_UNK;
    endcase
  endfunction

  logic [13:0]      samp_q, acc_q, pair_in;
  logic [RUN_W-1:0] run_q, run_d;
  logic             accept;
  logic [4:0]       tok;

  // Count consecutive identical samples. The count saturates at STABLE_CYC.
  // A pair is accepted on the edge where the run of identical samples reaches STABLE_CYC,
  // provided the pair differs from the last accepted pair.
  always_comb begin
    pair_in = {seg2_i, seg_i};
    run_d   = RUN_W'(1);
    if (pair_in == samp_q)
      run_d = (run_q >= RUN_W'(STABLE_CYC)) ? run_q : run_q + RUN_W'(1);
    accept  = (run_d >= RUN_W'(STABLE_CYC)) && (pair_in != acc_q);
    tok     = decode(pair_in);
  end

  // Input sample register, stability counter and last accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      run_q  <= '0;
      acc_q  <= IDLE_PAIR;
    end else begin
      samp_q <= pair_in;
      run_q  <= run_d;
      if (accept) acc_q <= pair_in;
    end
  end

  mon_state_e       state_q;
  logic [1:0]       prog_q;
  logic [3:0]       idx_q;
  logic             step_valid_q, wash_done_q, abort_q, seq_err_q;
  logic [4:0]       step_code_q;
  logic [CNT_W-1:0] wash_count_q;

  // Sequence monitor. Every output pulse is registered on the edge that accepts the token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MON_IDLE;
      prog_q       <= 2'd0;
      idx_q        <= 4'd0;
      step_valid_q <= 1'b0;
      step_code_q  <= T_IDLE;
      wash_done_q  <= 1'b0;
      abort_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      wash_count_q <= '0;
    end else begin
      step_valid_q <= 1'b0;
      wash_done_q  <= 1'b0;
      abort_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      if (accept) begin
        step_valid_q <= 1'b1;
        step_code_q  <= tok;
        case (state_q)
          MON_IDLE: begin
            if (tok == T_BP || tok == T_EP || tok == T_PP) begin
              prog_q  <= (tok == T_BP) ? 2'd1 : (tok == T_EP) ? 2'd2 : 2'd3;
              idx_q   <= 4'd1;
              state_q <= MON_RUN;
            end else if (tok != T_IDLE) begin
              seq_err_q <= 1'b1;
              state_q   <= MON_ERR;
            end
          end
          MON_RUN: begin
            if (tok == expected(prog_q, idx_q)) begin
              idx_q <= idx_q + 4'd1;
              if (tok == T_NINE) state_q <= MON_DONE;
            end else if (tok == T_IDLE) begin
              abort_q <= 1'b1;
              prog_q  <= 2'd0;
              state_q <= MON_IDLE;
            end else begin
              seq_err_q <= 1'b1;
              prog_q    <= 2'd0;
              state_q   <= MON_ERR;
            end
          end
          MON_DONE: begin
            prog_q <= 2'd0;
            if (tok == T_IDLE) begin
              wash_done_q  <= 1'b1;
              wash_count_q <= wash_count_q + 1'b1;
              state_q      <= MON_IDLE;
            end else begin
              seq_err_q <= 1'b1;
              state_q   <= MON_ERR;
            end
          end
          default: begin
            // Stay silent until the controller returns to IDLE.
            if (tok == T_IDLE) state_q <= MON_IDLE;
          end
        endcase
      end
    end
  end

  assign step_valid_o = step_valid_q;
  assign step_code_o  = step_code_q;
  assign program_o    = prog_q;
  assign wash_done_o  = wash_done_q;
  assign abort_o      = abort_q;
  assign seq_err_o    = seq_err_q;
  assign wash_count_o = wash_count_q;

`ifdef CARWASH_MON_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Saturating error/abort counter. It is fed from the registered pulses,
  // so it updates one edge after the matching pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       err_cnt_q <= '0;
    else if ((seq_err_q || abort_q) && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_carwash_seg_monitor.sv
// Bench for carwash_seg_monitor (STABLE_CYC=2, CNT_W=2).
// Each table record drives one digit pair. Records that should be accepted push an
// expected record to a queue. The monitor pops that record when step_valid_o rises.
module tb_carwash_seg_monitor;
  localparam logic [6:0] DASH = 7'b0000001, CB = 7'b0011111, CP = 7'b1100111,
                         CE   = 7'b1001111, CS = 7'b1011011, CF = 7'b1000111,
                         CC   = 7'b1001110, CR = 7'b1000110, CI = 7'b0000110,
                         C9   = 7'b1110011, CU = 7'b0111110, CD = 7'b0111101,
                         CH   = 7'b0110111, BL = 7'b0000000, GL = 7'b1111111;

  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] seg2_i = DASH, seg_i = DASH;
  logic       step_valid_o, wash_done_o, abort_o, seq_err_o;
  logic [4:0] step_code_o;
  logic [1:0] program_o, wash_count_o;

  carwash_seg_monitor #(.STABLE_CYC(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .seg2_i(seg2_i), .seg_i(seg_i),
    .step_valid_o(step_valid_o), .step_code_o(step_code_o), .program_o(program_o),
    .wash_done_o(wash_done_o), .abort_o(abort_o), .seq_err_o(seq_err_o),
    .wash_count_o(wash_count_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] s2, s;
    logic [3:0] hold;
    logic       acc;
    logic [4:0] code;
    logic [1:0] prog;
    logic       done, abrt, err;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0, fails = 0;

  function automatic vec_t mk(input logic [6:0] s2, s, input int code, prog,
                              input logic done, abrt, err, input int cnt);
    vec_t v;
    v.s2 = s2; v.s = s; v.hold = 4'd3; v.acc = 1'b1; v.code = 5'(code);
    v.prog = 2'(prog); v.done = done; v.abrt = abrt; v.err = err; v.cnt = 2'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one pair for v.hold cycles, starting at a falling edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    seg2_i = v.s2; seg_i = v.s;
    if (v.acc) sb.push_back(v);
    repeat (int'(v.hold) - 1) @(negedge clk);
  endtask

  task automatic run_basic(input int cnt_after);
    apply(mk(CB, CP, 1, 1, 0, 0, 0, cnt_after - 1));
    apply(mk(CS, CF, 5, 1, 0, 0, 0, cnt_after - 1));
    apply(mk(CC, BL, 6, 1, 0, 0, 0, cnt_after - 1));
    apply(mk(CR, CI, 7, 1, 0, 0, 0, cnt_after - 1));
    apply(mk(C9, BL, 8, 1, 0, 0, 0, cnt_after - 1));
    apply(mk(DASH, DASH, 0, 0, 1, 0, 0, cnt_after));
  endtask

  // Scoreboard: compare each accepted token against the next expected record.
  always @(negedge clk) begin
    if (!rst) begin
      if (step_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_step", int'(step_code_o), -1);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("step_code", int'(step_code_o), int'(e.code));
          chk("program",   int'(program_o),   int'(e.prog));
          chk("wash_done", int'(wash_done_o), int'(e.done));
          chk("abort",     int'(abort_o),     int'(e.abrt));
          chk("seq_err",   int'(seq_err_o),   int'(e.err));
          chk("wash_count", int'(wash_count_o), int'(e.cnt));
        end
      end else if (wash_done_o || abort_o || seq_err_o) begin
        chk("pulse_without_step", 1, 0);
      end
    end
  end

  initial begin
    vec_t g;
    // Basic run
    vecs.push_back(mk(CB, CP, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(CS, CF, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(CC, BL, 6, 1, 0, 0, 0, 0));
    vecs.push_back(mk(CR, CI, 7, 1, 0, 0, 0, 0));
    vecs.push_back(mk(C9, BL, 8, 1, 0, 0, 0, 0));
    vecs.push_back(mk(DASH, DASH, 0, 0, 1, 0, 0, 1));
    // Premium full run
    vecs.push_back(mk(CP, CP, 3, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CP, CS, 4, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CC, BL, 6, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CS, CF, 5, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CC, BL, 6, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CR, CI, 7, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CU, CU, 9, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CC, BL, 6, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CR, CI, 7, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CD, BL, 10, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CR, CS, 11, 3, 0, 0, 0, 1));
    vecs.push_back(mk(CS, CH, 12, 3, 0, 0, 0, 1));
    vecs.push_back(mk(C9, BL, 8, 3, 0, 0, 0, 1));
    vecs.push_back(mk(DASH, DASH, 0, 0, 1, 0, 0, 2));
    // Express aborted after C
    vecs.push_back(mk(CE, CP, 2, 2, 0, 0, 0, 2));
    vecs.push_back(mk(CP, CS, 4, 2, 0, 0, 0, 2));
    vecs.push_back(mk(CC, BL, 6, 2, 0, 0, 0, 2));
    vecs.push_back(mk(DASH, DASH, 0, 0, 0, 1, 0, 2));
    // Basic with skipped C, ignored tokens, recovery
    vecs.push_back(mk(CB, CP, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(CS, CF, 5, 1, 0, 0, 0, 2));
    vecs.push_back(mk(CR, CI, 7, 0, 0, 0, 1, 2));
    vecs.push_back(mk(CD, BL, 10, 0, 0, 0, 0, 2));
    vecs.push_back(mk(CU, CU, 9, 0, 0, 0, 0, 2));
    vecs.push_back(mk(DASH, DASH, 0, 0, 0, 0, 0, 2));
    // New Basic run with a one-cycle glitch mid-run
    vecs.push_back(mk(CB, CP, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(CS, CF, 5, 1, 0, 0, 0, 2));
    g = mk(GL, GL, 0, 0, 0, 0, 0, 0); g.hold = 4'd1; g.acc = 1'b0;
    vecs.push_back(g);
    vecs.push_back(mk(CC, BL, 6, 1, 0, 0, 0, 2));
    vecs.push_back(mk(CR, CI, 7, 1, 0, 0, 0, 2));
    vecs.push_back(mk(C9, BL, 8, 1, 0, 0, 0, 2));
    vecs.push_back(mk(DASH, DASH, 0, 0, 1, 0, 0, 3));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_step_valid", int'(step_valid_o), 0);
    chk("rst_step_code",  int'(step_code_o),  0);
    chk("rst_program",    int'(program_o),    0);
    chk("rst_pulses",     int'({wash_done_o, abort_o, seq_err_o}), 0);
    chk("rst_wash_count", int'(wash_count_o), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_not_reaccepted", int'(step_code_o), 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    repeat (3) @(negedge clk);
    chk("count_after_table", int'(wash_count_o), 3);
    chk("sb_drained_table", sb.size(), 0);

    // Premium interrupted by reset right after RS is accepted
    apply(mk(CP, CP, 3, 3, 0, 0, 0, 3));
    apply(mk(CP, CS, 4, 3, 0, 0, 0, 3));
    apply(mk(CC, BL, 6, 3, 0, 0, 0, 3));
    apply(mk(CS, CF, 5, 3, 0, 0, 0, 3));
    apply(mk(CC, BL, 6, 3, 0, 0, 0, 3));
    apply(mk(CR, CI, 7, 3, 0, 0, 0, 3));
    apply(mk(CU, CU, 9, 3, 0, 0, 0, 3));
    apply(mk(CC, BL, 6, 3, 0, 0, 0, 3));
    apply(mk(CR, CI, 7, 3, 0, 0, 0, 3));
    apply(mk(CD, BL, 10, 3, 0, 0, 0, 3));
    apply(mk(CR, CS, 11, 3, 0, 0, 0, 3));
    chk("pre_rst_program", int'(program_o), 3);
    #2 rst = 1'b1; seg2_i = DASH; seg_i = DASH;
    #1;
    chk("midrun_rst_step_code", int'(step_code_o), 0);
    chk("midrun_rst_program",   int'(program_o),   0);
    chk("midrun_rst_count",     int'(wash_count_o), 0);
    chk("midrun_rst_pulses",    int'({step_valid_o, wash_done_o, abort_o, seq_err_o}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_quiet", int'(step_code_o), 0);

    // Four complete runs: the 2-bit count wraps 3 -> 0
    run_basic(1);
    run_basic(2);
    run_basic(3);
    run_basic(0);
    repeat (3) @(negedge clk);
    chk("count_wrapped", int'(wash_count_o), 0);
    chk("sb_drained_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
